// File: rtl/seq_mul_add_alu_if.sv
// rtl/seq_mul_add_alu_if.sv - request/result handshake bundle for seq_mul_add_alu
interface seq_mul_add_alu_if #(
  parameter int WIDTH = 8
);
  logic [1:0][WIDTH-1:0] data_i;
  logic [2:0]            sel_i;
  logic                  EA_i;
  logic                  EB_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  clr_acc_i;
  logic [2*WIDTH-1:0]    P_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  err_o;
  logic                  busy_o;

  modport slave (
    input  data_i, sel_i, EA_i, EB_i, valid_i, clr_acc_i, ready_i,
    output ready_o, P_o, valid_o, err_o, busy_o
  );

  modport master (
    output data_i, sel_i, EA_i, EB_i, valid_i, clr_acc_i, ready_i,
    input  ready_o, P_o, valid_o, err_o, busy_o
  );
endinterface

// File: rtl/seq_mul_add_alu.sv
// rtl/seq_mul_add_alu.sv - registered add/sub with sequential shift-add multiply and MAC
module seq_mul_add_alu #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  seq_mul_add_alu_if.slave  bus
);
  localparam int          PW = 2 * WIDTH;
  localparam int          CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [2:0]  ADD_MODE = 3'b000;
  localparam logic [2:0]  SUB_MODE = 3'b001;
  localparam logic [2:0]  MUL_MODE = 3'b010;
  localparam logic [2:0]  MAC_MODE = 3'b011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic [PW-1:0]    op_a, op_b, acc_base, step;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    err_d    = err_q;
    valid_d  = valid_q;

    op_a = bus.EA_i ? {{WIDTH{1'b0}}, bus.data_i[0]} : '0;
    op_b = bus.EB_i ? {{WIDTH{1'b0}}, bus.data_i[1]} : '0;

    // Clear is folded in ahead of any MAC add so a coincident clear yields just A*B.
    acc_base = bus.clr_acc_i ? '0 : acc_q;
    acc_d    = acc_base;
    step     = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          sel_d    = bus.sel_i;
          mcand_d  = op_a;
          mplier_d = op_b[WIDTH-1:0];
          prod_d   = '0;
          cnt_d    = '0;
          case (bus.sel_i)
            ADD_MODE: begin
              p_d = op_a + op_b; err_d = 1'b0; valid_d = 1'b1; state_d = DONE;
            end
            SUB_MODE: begin
              p_d = op_a - op_b; err_d = 1'b0; valid_d = 1'b1; state_d = DONE;
            end
            MUL_MODE, MAC_MODE: state_d = CALC;
            default: begin
              p_d = '0; err_d = 1'b1; valid_d = 1'b1; state_d = DONE;
            end
          endcase
        end
      end
      CALC: begin
        prod_d   = step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          valid_d = 1'b1;
          err_d   = 1'b0;
          if (sel_q == MAC_MODE) begin
            acc_d = acc_base + step;
            p_d   = acc_base + step;
          end else begin
            p_d = step;
          end
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.busy_o  = (state_q == CALC);
  assign bus.P_o     = p_q;
  assign bus.err_o   = err_q;
  assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_seq_mul_add_alu.sv
// tb/tb_seq_mul_add_alu.sv - directed table-driven bench for seq_mul_add_alu
module tb_seq_mul_add_alu;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   failures = 0;

  seq_mul_add_alu_if #(.WIDTH(8)) bus ();
  seq_mul_add_alu #(.WIDTH(8)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ea;
    logic        eb;
    logic [15:0] exp_p;
    logic        exp_err;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Issues one request and returns at the first falling edge where valid_o is seen.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic ea, input logic eb, input int clr_at,
                        output logic [15:0] p, output logic err, output int lat,
                        output int busy_cnt, output int rdy_low);
    @(negedge clk_i);
    bus.sel_i = sel; bus.data_i[0] = a; bus.data_i[1] = b;
    bus.EA_i = ea; bus.EB_i = eb; bus.valid_i = 1'b1;
    @(posedge clk_i);
    #1 bus.valid_i = 1'b0;
    lat = -1; busy_cnt = 0; rdy_low = 0; p = '0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      bus.clr_acc_i = (n == clr_at);
      if (bus.busy_o) busy_cnt++;
      if (!bus.ready_o) rdy_low++;
      if (bus.valid_o) begin
        lat = n; p = bus.P_o; err = bus.err_o;
        bus.clr_acc_i = 1'b0;
        break;
      end
    end
    bus.clr_acc_i = 1'b0;
  endtask

  logic [15:0] p;
  logic        err;
  int          lat, busy_cnt, rdy_low, vcount;

  initial begin
    vecs[0] = '{"add",      3'b000, 8'd200, 8'd100, 1'b1, 1'b1, 16'h012C, 1'b0, 1, 0};
    vecs[1] = '{"sub",      3'b001, 8'd3,   8'd5,   1'b1, 1'b1, 16'hFFFE, 1'b0, 1, 0};
    vecs[2] = '{"sub_eb0",  3'b001, 8'd7,   8'd99,  1'b1, 1'b0, 16'h0007, 1'b0, 1, 0};
    vecs[3] = '{"add_ea0",  3'b000, 8'd50,  8'd9,   1'b0, 1'b1, 16'h0009, 1'b0, 1, 0};
    vecs[4] = '{"mul_max",  3'b010, 8'd255, 8'd255, 1'b1, 1'b1, 16'hFE01, 1'b0, 9, 8};
    vecs[5] = '{"mac1",     3'b011, 8'd10,  8'd10,  1'b1, 1'b1, 16'd100,  1'b0, 9, 8};
    vecs[6] = '{"mul_mid",  3'b010, 8'd13,  8'd11,  1'b1, 1'b1, 16'd143,  1'b0, 9, 8};
    vecs[7] = '{"mac2",     3'b011, 8'd20,  8'd3,   1'b1, 1'b1, 16'd160,  1'b0, 9, 8};
    vecs[8] = '{"err_111",  3'b111, 8'd5,   8'd6,   1'b1, 1'b1, 16'h0000, 1'b1, 1, 0};
    vecs[9] = '{"err_100",  3'b100, 8'd1,   8'd1,   1'b1, 1'b1, 16'h0000, 1'b1, 1, 0};

    rst_ni = 1'b0;
    bus.data_i = '0; bus.sel_i = '0; bus.EA_i = 1'b1; bus.EB_i = 1'b1;
    bus.valid_i = 1'b0; bus.clr_acc_i = 1'b0; bus.ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_p", 32'(bus.P_o), 32'h0);
    check("rst_valid", 32'(bus.valid_o), 32'h0);
    check("rst_err", 32'(bus.err_o), 32'h0);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_ready", 32'(bus.ready_o), 32'h1);
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb, 0, p, err, lat, busy_cnt, rdy_low);
      check({vecs[i].name, "_p"}, 32'(p), 32'(vecs[i].exp_p));
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_busy"}, 32'(busy_cnt), 32'(vecs[i].exp_busy));
      check({vecs[i].name, "_rdy_low"}, 32'(rdy_low), 32'(vecs[i].exp_lat));
      @(negedge clk_i);
      check({vecs[i].name, "_valid_drop"}, 32'(bus.valid_o), 32'h0);
    end

    // Clear in IDLE, then a fresh MAC starts from zero.
    bus.clr_acc_i = 1'b1;
    @(negedge clk_i);
    bus.clr_acc_i = 1'b0;
    run_op(3'b011, 8'd2, 8'd2, 1'b1, 1'b1, 0, p, err, lat, busy_cnt, rdy_low);
    check("mac_after_clr", 32'(p), 32'd4);
    @(negedge clk_i);

    // Clear sampled on the completion edge (8th CALC cycle) of 5*5.
    run_op(3'b011, 8'd5, 8'd5, 1'b1, 1'b1, 8, p, err, lat, busy_cnt, rdy_low);
    check("mac_clr_coincide", 32'(p), 32'd25);
    check("mac_clr_lat", 32'(lat), 32'd9);
    @(negedge clk_i);

    // Backpressure in DONE.
    bus.ready_i = 1'b0;
    run_op(3'b010, 8'd6, 8'd7, 1'b1, 1'b1, 0, p, err, lat, busy_cnt, rdy_low);
    check("bp_p", 32'(p), 32'd42);
    for (int k = 0; k < 5; k++) begin
      bus.valid_i = k[0]; bus.sel_i = 3'b000; bus.data_i[0] = 8'd1; bus.data_i[1] = 8'd1;
      @(negedge clk_i);
      check("bp_hold_valid", 32'(bus.valid_o), 32'h1);
      check("bp_hold_p", 32'(bus.P_o), 32'd42);
      check("bp_ready_low", 32'(bus.ready_o), 32'h0);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_valid", 32'(bus.valid_o), 32'h0);
    check("bp_release_p_held", 32'(bus.P_o), 32'd42);
    check("bp_release_idle", 32'(bus.ready_o), 32'h1);

    // Async reset mid-CALC.
    @(negedge clk_i);
    bus.sel_i = 3'b011; bus.data_i[0] = 8'd9; bus.data_i[1] = 8'd9; bus.valid_i = 1'b1;
    @(posedge clk_i);
    #1 bus.valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_rst_busy", 32'(bus.busy_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_p", 32'(bus.P_o), 32'h0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'h0);
    check("mid_rst_valid", 32'(bus.valid_o), 32'h0);
    check("mid_rst_err", 32'(bus.err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (bus.valid_o) vcount++;
    end
    check("post_rst_no_valid", 32'(vcount), 32'h0);
    check("post_rst_ready", 32'(bus.ready_o), 32'h1);
    run_op(3'b011, 8'd3, 8'd4, 1'b1, 1'b1, 0, p, err, lat, busy_cnt, rdy_low);
    check("post_rst_acc_zero", 32'(p), 32'd12);
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
